// File: rtl/ex_hilo_stage.sv
// ---------------------------------------------------------------------------
// ex_hilo_stage
//
// Execute-to-writeback boundary stage. Registers the ALU result, zero flag
// and destination information into a one-entry valid/ready slot, and owns
// the architectural HI/LO register pair. HI/LO writes ride along with the
// staged entry and commit only when that entry retires, so flushing the
// slot discards any in-flight HI/LO update.
//
// Optional feature macro: HILO_FWD_EN
//   defined   - MFHI/MFLO read the staged pending HI/LO write when that half
//               is enabled; no hazard stall.
//   undefined - MFHI/MFLO read the architectural register only; an incoming
//               MFHI/MFLO stalls (in_ready_o=0) while a matching write is
//               staged, costing one bubble.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   in_valid_i   in   1   upstream entry present
//   in_ready_o   out  1   stage accepts the entry this cycle
//   aluop_i      in   5   ALU op code (ALUOP_* in ex_hilo_pkg)
//   aluout_i     in   64  ALU result ({hi,lo} for MULT/DIV family)
//   zero_i       in   1   ALU zero flag
//   src0_i       in   32  rs value, data source for MTHI/MTLO
//   waddr_i      in   5   destination GPR
//   wen_i        in   1   destination write request
//   flush_i      in   1   discard the staged entry (wins over everything)
//   out_valid_o  out  1   staged entry present
//   out_ready_i  in   1   downstream accepts the staged entry
//   wb_data_o    out  32  write-back data
//   wb_addr_o    out  5   write-back address
//   wb_en_o      out  1   effective GPR write enable
//   zero_o       out  1   registered zero flag
//   hi_o         out  32  architectural HI
//   lo_o         out  32  architectural LO
// ---------------------------------------------------------------------------

package ex_hilo_pkg;

  localparam logic [4:0] ALUOP_NOP   = 5'd0;
  localparam logic [4:0] ALUOP_ADD   = 5'd1;
  localparam logic [4:0] ALUOP_ADDU  = 5'd2;
  localparam logic [4:0] ALUOP_SUB   = 5'd3;
  localparam logic [4:0] ALUOP_SUBU  = 5'd4;
  localparam logic [4:0] ALUOP_AND   = 5'd5;
  localparam logic [4:0] ALUOP_OR    = 5'd6;
  localparam logic [4:0] ALUOP_XOR   = 5'd7;
  localparam logic [4:0] ALUOP_NOR   = 5'd8;
  localparam logic [4:0] ALUOP_SLT   = 5'd9;
  localparam logic [4:0] ALUOP_SLTU  = 5'd10;
  localparam logic [4:0] ALUOP_SLL   = 5'd11;
  localparam logic [4:0] ALUOP_SRL   = 5'd12;
  localparam logic [4:0] ALUOP_SRA   = 5'd13;
  localparam logic [4:0] ALUOP_LUI   = 5'd14;
  localparam logic [4:0] ALUOP_MULT  = 5'd15;
  localparam logic [4:0] ALUOP_MULTU = 5'd16;
  localparam logic [4:0] ALUOP_DIV   = 5'd17;
  localparam logic [4:0] ALUOP_DIVU  = 5'd18;
  localparam logic [4:0] ALUOP_MFHI  = 5'd19;
  localparam logic [4:0] ALUOP_MFLO  = 5'd20;
  localparam logic [4:0] ALUOP_MTHI  = 5'd21;
  localparam logic [4:0] ALUOP_MTLO  = 5'd22;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : ex_hilo_pkg

module ex_hilo_stage
  import ex_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [4:0]  aluop_i,
  input  logic [63:0] aluout_i,
  input  logic        zero_i,
  input  logic [31:0] src0_i,
  input  logic [4:0]  waddr_i,
  input  logic        wen_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_addr_o,
  output logic        wb_en_o,
  output logic        zero_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  slot_state_e state_q, state_d;

  logic [31:0] wb_data_q,   wb_data_d;
  logic [4:0]  wb_addr_q,   wb_addr_d;
  logic        wb_en_q,     wb_en_d;
  logic        zero_q,      zero_d;

  // Pending HI/LO write carried by the staged entry.
  logic [31:0] pend_hi_q,    pend_hi_d;
  logic [31:0] pend_lo_q,    pend_lo_d;
  logic        pend_hi_en_q, pend_hi_en_d;
  logic        pend_lo_en_q, pend_lo_en_d;

  // Architectural HI/LO.
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // -------------------------------------------------------------------------
  // Incoming op decode
  // -------------------------------------------------------------------------
  logic is_muldiv;
  logic is_mthi;
  logic is_mtlo;
  logic is_mfhi;
  logic is_mflo;
  logic is_nop;

  always_comb begin
    is_muldiv = (aluop_i == ALUOP_MULT)  || (aluop_i == ALUOP_MULTU) ||
                (aluop_i == ALUOP_DIV)   || (aluop_i == ALUOP_DIVU);
    is_mthi   = (aluop_i == ALUOP_MTHI);
    is_mtlo   = (aluop_i == ALUOP_MTLO);
    is_mfhi   = (aluop_i == ALUOP_MFHI);
    is_mflo   = (aluop_i == ALUOP_MFLO);
    is_nop    = (aluop_i == ALUOP_NOP);
  end

  // -------------------------------------------------------------------------
  // HI/LO view seen by an incoming MFHI/MFLO, and the read-after-write hazard
  // -------------------------------------------------------------------------
  logic        slot_full;
  logic        hazard;
  logic [31:0] hi_view;
  logic [31:0] lo_view;

  assign slot_full = (state_q == SLOT_FULL);

`ifdef HILO_FWD_EN
  // Bypass the staged write so the reader never waits for the writer.
  assign hi_view = (slot_full && pend_hi_en_q) ? pend_hi_q : hi_q;
  assign lo_view = (slot_full && pend_lo_en_q) ? pend_lo_q : lo_q;
  assign hazard  = 1'b0;
`else
  // No bypass: hold off the reader until the writer has committed HI/LO.
  assign hi_view = hi_q;
  assign lo_view = lo_q;
  assign hazard  = slot_full &&
                   ((pend_hi_en_q && is_mfhi) || (pend_lo_en_q && is_mflo));
`endif

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic accept;
  logic retire;

  assign in_ready_o = (!slot_full || out_ready_i) && !hazard;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign retire     = slot_full && out_ready_i && !flush_i;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first, so no path through the
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wb_data_d    = wb_data_q;
    wb_addr_d    = wb_addr_q;
    wb_en_d      = wb_en_q;
    zero_d       = zero_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_hi_en_d = pend_hi_en_q;
    pend_lo_en_d = pend_lo_en_q;
    hi_d         = hi_q;
    lo_d         = lo_q;

    // Slot occupancy.
    unique case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (retire && !accept) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
    if (flush_i) state_d = SLOT_EMPTY;

    // HI/LO commit uses the entry being retired, before it is overwritten.
    if (retire) begin
      if (pend_hi_en_q) hi_d = pend_hi_q;
      if (pend_lo_en_q) lo_d = pend_lo_q;
    end

    if (accept) begin
      // Capture a new entry.
      if (is_mfhi)      wb_data_d = hi_view;
      else if (is_mflo) wb_data_d = lo_view;
      else              wb_data_d = aluout_i[31:0];

      wb_addr_d = waddr_i;
      wb_en_d   = wen_i && (waddr_i != 5'd0) &&
                  !(is_muldiv || is_mthi || is_mtlo || is_nop);
      zero_d    = zero_i;

      pend_hi_en_d = is_muldiv || is_mthi;
      pend_lo_en_d = is_muldiv || is_mtlo;
      pend_hi_d    = is_muldiv ? aluout_i[63:32] : src0_i;
      pend_lo_d    = is_muldiv ? aluout_i[31:0]  : src0_i;
    end else if (state_d == SLOT_EMPTY) begin
      // Slot drains (retire or flush): drop anything that could act later.
      wb_en_d      = 1'b0;
      pend_hi_en_d = 1'b0;
      pend_lo_en_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments make every flop sample the pre-edge value
  // of every other flop, regardless of statement order.
  // NOTE: all flops, including the pending data words, are reset so the
  // outputs read a defined 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SLOT_EMPTY;
      wb_data_q    <= '0;
      wb_addr_q    <= '0;
      wb_en_q      <= 1'b0;
      zero_q       <= 1'b0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_hi_en_q <= 1'b0;
      pend_lo_en_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      wb_data_q    <= wb_data_d;
      wb_addr_q    <= wb_addr_d;
      wb_en_q      <= wb_en_d;
      zero_q       <= zero_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_hi_en_q <= pend_hi_en_d;
      pend_lo_en_q <= pend_lo_en_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid_o = slot_full;
  assign wb_data_o   = wb_data_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_en_o     = wb_en_q;
  assign zero_o      = zero_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule : ex_hilo_stage

// File: tb/tb_ex_hilo_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_hilo_stage
//
// Directed self-checking bench for ex_hilo_stage. Inputs change 1 time unit
// after each rising edge; outputs are compared at that same point, away from
// the edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ex_hilo_stage;
  import ex_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  aluop_i;
  logic [63:0] aluout_i;
  logic        zero_i;
  logic [31:0] src0_i;
  logic [4:0]  waddr_i;
  logic        wen_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_addr_o;
  logic        wb_en_o;
  logic        zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int tests = 0;
  int fails = 0;

  ex_hilo_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .aluop_i     (aluop_i),
    .aluout_i    (aluout_i),
    .zero_i      (zero_i),
    .src0_i      (src0_i),
    .waddr_i     (waddr_i),
    .wen_i       (wen_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .wb_data_o   (wb_data_o),
    .wb_addr_o   (wb_addr_o),
    .wb_en_o     (wb_en_o),
    .zero_o      (zero_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op,
                       input logic [63:0] alu, input logic [31:0] s0,
                       input logic [4:0] wa, input logic we);
    in_valid_i = v;
    aluop_i    = op;
    aluout_i   = alu;
    src0_i     = s0;
    waddr_i    = wa;
    wen_i      = we;
  endtask

  task automatic idle();
    drive(1'b0, ALUOP_NOP, 64'd0, 32'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    zero_i      = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    idle();

    // ---- reset state ----
    #2;
    check("rst_valid",   64'(out_valid_o), 64'd0);
    check("rst_data",    64'(wb_data_o),   64'd0);
    check("rst_addr",    64'(wb_addr_o),   64'd0);
    check("rst_wben",    64'(wb_en_o),     64'd0);
    check("rst_zero",    64'(zero_o),      64'd0);
    check("rst_hi",      64'(hi_o),        64'd0);
    check("rst_lo",      64'(lo_o),        64'd0);
    check("rst_ready",   64'(in_ready_o),  64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // ---- MULT staged then retired ----
    drive(1'b1, ALUOP_MULT, 64'hFFFF_FFFF_FFFF_FFFE, 32'd0, 5'd5, 1'b1);
    step();
    check("mult_valid",  64'(out_valid_o), 64'd1);
    check("mult_wben",   64'(wb_en_o),     64'd0);
    check("mult_hi_pre", 64'(hi_o),        64'd0);
    idle();
    step();
    check("mult_drain",  64'(out_valid_o), 64'd0);
    check("mult_hi",     64'(hi_o),        64'h0000_0000_FFFF_FFFF);
    check("mult_lo",     64'(lo_o),        64'h0000_0000_FFFF_FFFE);

    // ---- ADD staged and held under backpressure ----
    out_ready_i = 1'b0;
    drive(1'b1, ALUOP_ADD, 64'd5, 32'd0, 5'd3, 1'b1);
    step();
    check("add_valid",   64'(out_valid_o), 64'd1);
    check("add_data",    64'(wb_data_o),   64'd5);
    check("add_addr",    64'(wb_addr_o),   64'd3);
    check("add_wben",    64'(wb_en_o),     64'd1);
    drive(1'b1, ALUOP_ADD, 64'd9, 32'd0, 5'd4, 1'b1);
    #1;
    check("hold_ready0", 64'(in_ready_o),  64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 64'(out_valid_o), 64'd1);
      check("hold_data",  64'(wb_data_o),   64'd5);
      check("hold_addr",  64'(wb_addr_o),   64'd3);
      check("hold_ready", 64'(in_ready_o),  64'd0);
    end
    idle();
    out_ready_i = 1'b1;
    step();
    check("add_drain",   64'(out_valid_o), 64'd0);

    // ---- DIVU then MFLO: hazard / forwarding ----
    drive(1'b1, ALUOP_DIVU, {32'd7, 32'd3}, 32'd0, 5'd0, 1'b0);
    step();
    check("divu_valid",  64'(out_valid_o), 64'd1);
    drive(1'b1, ALUOP_MFLO, 64'd0, 32'd0, 5'd8, 1'b1);
    #1;
`ifdef HILO_FWD_EN
    check("mflo_ready",  64'(in_ready_o),  64'd1);
    step();
`else
    check("mflo_stall",  64'(in_ready_o),  64'd0);
    step();
    check("stall_empty", 64'(out_valid_o), 64'd0);
    check("stall_ready", 64'(in_ready_o),  64'd1);
    step();
`endif
    check("mflo_valid",  64'(out_valid_o), 64'd1);
    check("mflo_data",   64'(wb_data_o),   64'd3);
    check("mflo_wben",   64'(wb_en_o),     64'd1);
    check("divu_hi",     64'(hi_o),        64'd7);
    check("divu_lo",     64'(lo_o),        64'd3);
    drive(1'b1, ALUOP_MFHI, 64'd0, 32'd0, 5'd9, 1'b1);
    #1;
    check("mfhi_ready",  64'(in_ready_o),  64'd1);
    step();
    check("mfhi_data",   64'(wb_data_o),   64'd7);
    check("mfhi_addr",   64'(wb_addr_o),   64'd9);
    idle();
    step();
    check("mfhi_drain",  64'(out_valid_o), 64'd0);

    // ---- MTHI flushed: HI must not change; flush wins over accept ----
    drive(1'b1, ALUOP_MTHI, 64'd0, 32'h1234, 5'd0, 1'b0);
    step();
    check("mthi_valid",  64'(out_valid_o), 64'd1);
    drive(1'b1, ALUOP_ADD, 64'd77, 32'd0, 5'd6, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    idle();
    check("flush_empty", 64'(out_valid_o), 64'd0);
    check("flush_hi",    64'(hi_o),        64'd7);
    step();
    check("flush_hi2",   64'(hi_o),        64'd7);
    check("flush_empty2",64'(out_valid_o), 64'd0);

    // ---- MTLO retired: only LO changes ----
    drive(1'b1, ALUOP_MTLO, 64'd0, 32'hABCD, 5'd0, 1'b0);
    step();
    idle();
    step();
    check("mtlo_lo",     64'(lo_o),        64'hABCD);
    check("mtlo_hi",     64'(hi_o),        64'd7);

    // ---- back-to-back stream of 4 ADDs ----
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ALUOP_ADD, 64'(10 + i), 32'd0, 5'(i + 1), 1'b1);
      #1;
      check("strm_ready", 64'(in_ready_o),  64'd1);
      step();
      check("strm_valid", 64'(out_valid_o), 64'd1);
      check("strm_data",  64'(wb_data_o),   64'(10 + i));
      check("strm_addr",  64'(wb_addr_o),   64'(i + 1));
    end
    idle();
    step();
    check("strm_drain",  64'(out_valid_o), 64'd0);

    // ---- write to r0 suppressed; zero flag registered ----
    out_ready_i = 1'b0;
    zero_i      = 1'b1;
    drive(1'b1, ALUOP_ADD, 64'd0, 32'd0, 5'd0, 1'b1);
    step();
    zero_i = 1'b0;
    check("r0_valid",    64'(out_valid_o), 64'd1);
    check("r0_wben",     64'(wb_en_o),     64'd0);
    check("zero_flag",   64'(zero_o),      64'd1);

    // ---- asynchronous reset mid-stream ----
    drive(1'b1, ALUOP_ADD, 64'd55, 32'd0, 5'd2, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid",  64'(out_valid_o), 64'd0);
    check("arst_data",   64'(wb_data_o),   64'd0);
    check("arst_addr",   64'(wb_addr_o),   64'd0);
    check("arst_wben",   64'(wb_en_o),     64'd0);
    check("arst_zero",   64'(zero_o),      64'd0);
    check("arst_hi",     64'(hi_o),        64'd0);
    check("arst_lo",     64'(lo_o),        64'd0);
    idle();
    #2;
    rst = 1'b0;
    step();
    check("post_rst",    64'(out_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ex_hilo_stage
